// File: rtl/alu_mc_handshake_if.sv
// Handshake bundle between the EX-stage issue logic and the multi-cycle ALU.
// The slave side is the ALU. The master side is the upstream producer together with the downstream consumer.
interface alu_mc_handshake_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2:0]           alu_ctrl;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 overflow;
  logic                 div_zero;

  modport slave (
    input  in_valid, a, b, alu_ctrl, out_ready,
    output in_ready, out_valid, result, overflow, div_zero
  );

  modport master (
    output in_valid, a, b, alu_ctrl, out_ready,
    input  in_ready, out_valid, result, overflow, div_zero
  );
endinterface

// File: rtl/alu_mc_handshake.sv
// Registered EX-stage ALU with valid/ready on both sides.
// Single-cycle ops are ADD, SUB, MOVE, SWAP, AND and OR.
// MUL (shift-add) and DIV (restoring) run iteratively, producing one bit per cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | empty, accepting a new op
//   ST_BUSY | MUL/DIV iterating, cnt_q counts completed iterations
//   ST_DONE | result held on outputs until the consumer takes it
module alu_mc_handshake #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  alu_mc_handshake_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MOVE = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // MUL: {partial product hi, remaining multiplier bits}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0]   work_q, work_d;
  // MUL: multiplicand; DIV: divisor
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 dz_pend_q, dz_pend_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 overflow_q, overflow_d;
  logic                 div_zero_q, div_zero_d;

  logic                 accept;
  logic                 is_multi;
  logic [WIDTH-1:0]     sc_sum, sc_diff;
  logic [WIDTH-1:0]     sc_hi, sc_lo;
  logic                 sc_ovf;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem_sub;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   iter_next;

  assign bus.in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.div_zero  = div_zero_q;

  assign accept   = bus.in_valid & bus.in_ready;
  assign is_multi = (bus.alu_ctrl == OP_MUL) | (bus.alu_ctrl == OP_DIV);

  // Single-cycle result and signed overflow straight from the presented operands
  always_comb begin
    sc_hi   = '0;
    sc_lo   = '0;
    sc_ovf  = 1'b0;
    sc_sum  = bus.a + bus.b;
    sc_diff = bus.a - bus.b;
    case (bus.alu_ctrl)
      OP_ADD: begin
        sc_lo  = sc_sum;
        sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (sc_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo  = sc_diff;
        sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (sc_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_MOVE: sc_lo = bus.b;
      OP_SWAP: begin
        sc_hi = bus.a;
        sc_lo = bus.b;
      end
      OP_AND:  sc_lo = bus.a & bus.b;
      OP_OR:   sc_lo = bus.a | bus.b;
      default: begin
        sc_hi  = '0;
        sc_lo  = '0;
        sc_ovf = 1'b0;
      end
    endcase
  end

  // One MUL/DIV iteration on the work register
  always_comb begin
    // Add the multiplicand into the high half when the multiplier LSB is set, then shift right.
    // The extra carry bit shifts into the top.
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, work_q[WIDTH-1:1]};
    // Shift the next dividend bit into the remainder and subtract the divisor if it fits.
    // A zero divisor always fits, so the quotient becomes all ones and the remainder becomes a.
    div_ge      = (work_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd_q});
    div_rem_sub = work_q[2*WIDTH-2:WIDTH-1] - opnd_q;
    div_next    = div_ge ? {div_rem_sub, work_q[WIDTH-2:0], 1'b1}
                         : {work_q[2*WIDTH-2:WIDTH-1], work_q[WIDTH-2:0], 1'b0};
    iter_next   = is_div_q ? div_next : mul_next;
  end

  // Next-state and datapath-register update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    dz_pend_d  = dz_pend_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    div_zero_d = div_zero_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && bus.out_ready) begin
          state_d = ST_IDLE;
        end
        if (accept) begin
          if (is_multi) begin
            state_d  = ST_BUSY;
            cnt_d    = '0;
            is_div_d = (bus.alu_ctrl == OP_DIV);
            if (bus.alu_ctrl == OP_DIV) begin
              work_d    = {{WIDTH{1'b0}}, bus.a};
              opnd_d    = bus.b;
              dz_pend_d = (bus.b == '0);
            end else begin
              work_d    = {{WIDTH{1'b0}}, bus.b};
              opnd_d    = bus.a;
              dz_pend_d = 1'b0;
            end
          end else begin
            state_d    = ST_DONE;
            result_d   = {sc_hi, sc_lo};
            overflow_d = sc_ovf;
            div_zero_d = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        work_d = iter_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_DONE;
          cnt_d      = '0;
          result_d   = iter_next;
          overflow_d = 1'b0;
          div_zero_d = dz_pend_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset discards any in-flight op
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      dz_pend_q  <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      dz_pend_q  <= dz_pend_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule
